nibble_cascade_cmp: RTL and testbench
=====================================

Name: nibble_cascade_cmp

Overview:
- Downstream consumer of the 4-bit comparator's G/E/L outputs; resolves a wide comparison over NIBBLES × 4-bit operands.
- Receives per-nibble results MSB-first over a valid/ready stream and emits one registered G/E/L verdict per word.
- Lets the existing 4-bit comparator be time-multiplexed to compare 16-bit or wider operands.

Parameters:
- NIBBLES, 4, nibbles per word (operand width = 4*NIBBLES); legal range ≥ 2.
- CNT_W, 16, width of the statistics counters (used only with CMP_STATS_EN).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  a nibble result is presented.
- in_ready  output  1  block accepts a nibble this cycle.
- in_first  input  1  marks the beat as the MSB nibble of a new word.
- G_in  input  1  nibble a>b.
- E_in  input  1  nibble a==b.
- L_in  input  1  nibble a<b.
- out_valid  output  1  word verdict available.
- out_ready  input  1  downstream accepts the verdict.
- G  output  1  word a>b.
- E  output  1  word a==b.
- L  output  1  word a<b.
- err  output  1  word contained a non-one-hot nibble result.

Behaviour:
- Beat accepted when in_valid && in_ready. Verdict consumed when out_valid && out_ready.
- Reset (rst_n=0 at an edge):
  - state=IDLE, nib_cnt=0, decided=0.
  - out_valid=0, G=0, E=0, L=0, err=0, in_ready=1.
  - A partial word or pending verdict is discarded; reset overrides all other inputs.
- FSM IDLE:
  - in_ready=1.
  - An accepted beat is nibble 0, whether or not in_first is set; go to ACCUM, nib_cnt=1.
  - Latch the verdict from the beat: decided=1 if G_in or L_in; err_acc=1 if not one-hot.
- FSM ACCUM:
  - in_ready=1.
  - Accepted beat with in_first=1: discard the partial word and restart as nibble 0 (nib_cnt=1); counts as a dropped word.
  - Other accepted beats:
    - If decided=0, take the verdict from this beat.
    - If decided=1, ignore G_in/L_in; the MSB-most non-equal nibble wins.
    - One-hot checking still applies to every beat.
  - Accepting nibble NIBBLES-1 goes to DONE.
- FSM DONE:
  - out_valid=1, in_ready=0.
  - G/E/L/err registered, stable while out_valid && !out_ready.
  - Verdict encoding:
    - err=1 → G=E=L=0.
    - decided=0 → E=1.
    - Otherwise exactly one of G/L is set.
  - Handshake → IDLE, out_valid=0 next cycle.
- Latency: verdict visible the cycle after the last nibble is accepted. Minimum period is NIBBLES+1 cycles per word; no acceptance while in DONE.
- No beats: the block stays in IDLE indefinitely with no output change.
- nib_cnt width is $clog2(NIBBLES). It never wraps past NIBBLES-1 because the FSM exits to DONE.
- The one-hot check treats G_in/E_in/L_in = 000, 110, 011, 101, and 111 as illegal.

Optional Feature:
- Macro CMP_STATS_EN.
- Defined:
  - Adds outputs words_done [CNT_W-1:0] and words_dropped [CNT_W-1:0], both reset to 0.
  - words_done increments on each output handshake.
  - words_dropped increments on each in_first restart in ACCUM.
  - Both counters saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Words 0x5A3C vs 0x5A7C (beats E,E,L,E) with out_ready=1 → out_valid the cycle after beat 4, L=1, G=0, E=0, err=0; in_ready=0 that cycle.
- Equal words 0x1234 vs 0x1234 (E,E,E,E) → E=1, G=L=0; then 0x9000 vs 0x1FFF (G,L,L,L) → G=1; later nibbles are ignored.
- Beat 2 driven with G_in=E_in=1, others legal → err=1, G=E=L=0 on the verdict.
- Verdict pending with out_ready=0 for 3 cycles → G/E/L/err and out_valid held, in_ready=0; on the 4th cycle out_ready=1 → IDLE next cycle, in_ready=1.
- Two beats (E,G), then in_first=1 with L, followed by E,E,E → verdict L=1; with CMP_STATS_EN, words_dropped=1 and words_done=1.
- rst_n=0 for one edge after 2 beats of a word → out_valid=0, in_ready=1; the next 4 beats (G,E,E,E) yield G=1 and no residue from the aborted word.

Source files
------------

// File: rtl/nibble_cascade_cmp.sv
`timescale 1ns/1ps
// Purpose: folds MSB-first 4-bit comparator results (G/E/L per nibble) into one word-wide verdict.
// Latency: the verdict is registered and visible the cycle after the last nibble of a word is accepted.
// Backpressure: in_ready drops while a verdict waits. The verdict stays held until out_ready.
// Optional build macro CMP_STATS_EN adds saturating words_done / words_dropped counters.
module nibble_cascade_cmp #(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             G_in,
  input  logic             E_in,
  input  logic             L_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             G,
  output logic             E,
  output logic             L,
  output logic             err
`ifdef CMP_STATS_EN
  ,
  output logic [CNT_W-1:0] words_done,
  output logic [CNT_W-1:0] words_dropped
`endif
);

  // nib_cnt only has to hold 0..NIBBLES-1. The FSM leaves for DONE before the counter could wrap.
  localparam int              CW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(NIBBLES - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  // Reject configurations the cascade cannot represent when the design is elaborated.
  if (NIBBLES < 2 || CNT_W < 1) begin : g_bad_param
    $error("nibble_cascade_cmp: NIBBLES must be >= 2 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  nib_cnt, nib_cnt_nxt;
  // decided: a non-equal nibble has been seen, so later nibbles cannot change the outcome.
  // gt_acc: the direction of that first non-equal nibble (1 = a>b).
  logic           decided, decided_nxt;
  logic           gt_acc, gt_acc_nxt;
  logic           err_acc, err_acc_nxt;
  logic           g_nxt, e_nxt, l_nxt, err_nxt;
  logic           beat_onehot;

  // A nibble result is legal only when exactly one of G/E/L is set.
  assign beat_onehot = ( G_in & ~E_in & ~L_in) |
                       (~G_in &  E_in & ~L_in) |
                       (~G_in & ~E_in &  L_in);

  // Next-state, accumulator update and handshake outputs.
  always_comb begin
    state_nxt   = state;
    nib_cnt_nxt = nib_cnt;
    decided_nxt = decided;
    gt_acc_nxt  = gt_acc;
    err_acc_nxt = err_acc;
    g_nxt       = G;
    e_nxt       = E;
    l_nxt       = L;
    err_nxt     = err;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        // Any beat that arrives here is nibble 0. in_first is not required.
        if (in_valid) begin
          state_nxt   = ACCUM;
          nib_cnt_nxt = ONE;
          decided_nxt = G_in | L_in;
          gt_acc_nxt  = G_in;
          err_acc_nxt = ~beat_onehot;
        end
      end

      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_first) begin
            // A new word started early. Drop the partial word and treat this beat as nibble 0.
            nib_cnt_nxt = ONE;
            decided_nxt = G_in | L_in;
            gt_acc_nxt  = G_in;
            err_acc_nxt = ~beat_onehot;
          end else begin
            // The most significant non-equal nibble wins. Later nibbles only feed the legality check.
            if (!decided) begin
              decided_nxt = G_in | L_in;
              gt_acc_nxt  = G_in;
            end
            err_acc_nxt = err_acc | ~beat_onehot;
            if (nib_cnt == LAST) begin
              state_nxt   = DONE;
              nib_cnt_nxt = '0;
              // An error suppresses the verdict. No decision means the words are equal.
              err_nxt     = err_acc_nxt;
              g_nxt       = ~err_acc_nxt &  decided_nxt &  gt_acc_nxt;
              l_nxt       = ~err_acc_nxt &  decided_nxt & ~gt_acc_nxt;
              e_nxt       = ~err_acc_nxt & ~decided_nxt;
            end else begin
              nib_cnt_nxt = nib_cnt + ONE;
            end
          end
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt   = IDLE;
          decided_nxt = 1'b0;
          gt_acc_nxt  = 1'b0;
          err_acc_nxt = 1'b0;
          g_nxt       = 1'b0;
          e_nxt       = 1'b0;
          l_nxt       = 1'b0;
          err_nxt     = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and verdict registers. Reset discards any partial word or pending verdict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      nib_cnt <= '0;
      decided <= 1'b0;
      gt_acc  <= 1'b0;
      err_acc <= 1'b0;
      G       <= 1'b0;
      E       <= 1'b0;
      L       <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      nib_cnt <= nib_cnt_nxt;
      decided <= decided_nxt;
      gt_acc  <= gt_acc_nxt;
      err_acc <= err_acc_nxt;
      G       <= g_nxt;
      E       <= e_nxt;
      L       <= l_nxt;
      err     <= err_nxt;
    end
  end

`ifdef CMP_STATS_EN
  logic word_done;
  logic word_restart;

  assign word_done    = (state == DONE) & out_ready;
  assign word_restart = (state == ACCUM) & in_valid & in_first;

  // Saturating counters for completed verdicts and abandoned partial words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_done    <= '0;
      words_dropped <= '0;
    end else begin
      if (word_done && (words_done != {CNT_W{1'b1}}))
        words_done <= words_done + 1'b1;
      if (word_restart && (words_dropped != {CNT_W{1'b1}}))
        words_dropped <= words_dropped + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_cascade_cmp.sv
`timescale 1ns/1ps
// Directed bench for nibble_cascade_cmp with NIBBLES=4.
// Each nibble result is driven as {G_in,E_in,L_in}, and checks compare hand-computed vectors.
// Packed check vector: {out_valid, in_ready, G, E, L, err}.
module tb_nibble_cascade_cmp;
  localparam int CNT_W = 16;

  localparam logic [2:0] BG  = 3'b100;
  localparam logic [2:0] BE  = 3'b010;
  localparam logic [2:0] BL  = 3'b001;
  localparam logic [2:0] BGE = 3'b110;
  localparam logic [2:0] BZ  = 3'b000;
  localparam logic [2:0] BA  = 3'b111;

  localparam logic [5:0] V_IDLE = 6'b010000;
  localparam logic [5:0] V_GT   = 6'b101000;
  localparam logic [5:0] V_EQ   = 6'b100100;
  localparam logic [5:0] V_LT   = 6'b100010;
  localparam logic [5:0] V_ERR  = 6'b100001;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_first, G_in, E_in, L_in;
  logic out_valid, out_ready, G, E, L, err;
`ifdef CMP_STATS_EN
  logic [CNT_W-1:0] words_done, words_dropped;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_cascade_cmp #(.NIBBLES(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .G_in      (G_in),
    .E_in      (E_in),
    .L_in      (L_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .G         (G),
    .E         (E),
    .L         (L),
    .err       (err)
`ifdef CMP_STATS_EN
    ,
    .words_done    (words_done),
    .words_dropped (words_dropped)
`endif
  );

  function automatic logic [5:0] obs();
    return {out_valid, in_ready, G, E, L, err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic beat(input logic first, input logic [2:0] gel);
    in_valid = 1'b1;
    in_first = first;
    {G_in, E_in, L_in} = gel;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    {G_in, E_in, L_in} = BZ;
  endtask

  task automatic word4(input logic first0, input logic [2:0] b0, input logic [2:0] b1,
                       input logic [2:0] b2, input logic [2:0] b3);
    beat(first0, b0);
    beat(1'b0, b1);
    beat(1'b0, b2);
    beat(1'b0, b3);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0;
    G_in = 1'b0; E_in = 1'b0; L_in = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("reset_state", 32'(obs()), 32'(V_IDLE));
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_no_beats", 32'(obs()), 32'(V_IDLE));

    // 0x5A3C vs 0x5A7C gives beats E,E,L,E.
    beat(1'b1, BE); beat(1'b0, BE); beat(1'b0, BL);
    chk("t1_mid_word", 32'(obs()), 32'(V_IDLE));
    beat(1'b0, BE);
    chk("t1_verdict_lt", 32'(obs()), 32'(V_LT));
    tick();
    chk("t1_consumed", 32'(obs()), 32'(V_IDLE));

    // Equal words give E. Then G,L,L,L gives G, with no in_first on nibble 0.
    word4(1'b1, BE, BE, BE, BE);
    chk("t2_equal", 32'(obs()), 32'(V_EQ));
    tick();
    word4(1'b0, BG, BL, BL, BL);
    chk("t2_msb_wins_gt", 32'(obs()), 32'(V_GT));
    tick();

    // Illegal nibble results force err=1 and suppress G/E/L.
    word4(1'b1, BE, BGE, BE, BE);
    chk("t3_err_110", 32'(obs()), 32'(V_ERR));
    tick();
    word4(1'b1, BL, BG, BE, BZ);
    chk("t3_err_000_after_decide", 32'(obs()), 32'(V_ERR));
    tick();
    word4(1'b1, BA, BE, BE, BE);
    chk("t3_err_111_first", 32'(obs()), 32'(V_ERR));
    tick();
    word4(1'b1, BE, BE, BE, BE);
    chk("t3_err_cleared", 32'(obs()), 32'(V_EQ));
    tick();

    // Backpressure: the verdict is held and no beat is accepted while it waits.
    out_ready = 1'b0;
    word4(1'b1, BE, BE, BE, BG);
    chk("t4_hold0", 32'(obs()), 32'(V_GT));
    in_valid = 1'b1; in_first = 1'b1; {G_in, E_in, L_in} = BL;
    tick();
    chk("t4_hold1", 32'(obs()), 32'(V_GT));
    tick();
    chk("t4_hold2", 32'(obs()), 32'(V_GT));
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_first = 1'b0; {G_in, E_in, L_in} = BZ;
    chk("t4_released", 32'(obs()), 32'(V_IDLE));
    tick();
    chk("t4_no_stray_beat", 32'(obs()), 32'(V_IDLE));

    // A restart through in_first drops the partial word (E,G) and keeps the new one.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    beat(1'b1, BE); beat(1'b0, BG);
    beat(1'b1, BL); beat(1'b0, BE); beat(1'b0, BE);
    chk("t5_mid_word", 32'(obs()), 32'(V_IDLE));
    beat(1'b0, BE);
    chk("t5_restart_lt", 32'(obs()), 32'(V_LT));
`ifdef CMP_STATS_EN
    chk("t5_dropped", 32'(words_dropped), 32'd1);
    chk("t5_done_pre", 32'(words_done), 32'd0);
`endif
    tick();
    chk("t5_consumed", 32'(obs()), 32'(V_IDLE));
`ifdef CMP_STATS_EN
    chk("t5_done", 32'(words_done), 32'd1);
`endif

    // Reset in the middle of a word discards it completely.
    beat(1'b1, BL); beat(1'b0, BE);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_after_reset", 32'(obs()), 32'(V_IDLE));
`ifdef CMP_STATS_EN
    chk("t6_stats_cleared", 32'({words_done, words_dropped}), 32'd0);
`endif
    word4(1'b1, BG, BE, BE, BE);
    chk("t6_clean_gt", 32'(obs()), 32'(V_GT));
    tick();
    chk("t6_consumed", 32'(obs()), 32'(V_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
